// File: rtl/regfile_alu_sequencer.sv
// rtl/regfile_alu_sequencer.sv - sequences one register-file/ALU command through read, execute and write-back
module regfile_alu_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic [3:0]        CmdOp,
    input  logic [ADDR_W-1:0] CmdRs,
    input  logic [ADDR_W-1:0] CmdRt,
    input  logic [ADDR_W-1:0] CmdRd,
    input  logic [4:0]        CmdShamt,
    input  logic [DATA_W-1:0] CmdImm,
    input  logic [DATA_W-1:0] AluResult,
    output logic [ADDR_W-1:0] RR1,
    output logic [ADDR_W-1:0] RR2,
    output logic [ADDR_W-1:0] WR,
    output logic              WE,
    output logic [DATA_W-1:0] WD,
    output logic              Mux_Ctrl,
    output logic [3:0]        Op,
    output logic [4:0]        ShiftCount,
    output logic              Done,
    output logic              Err,
    output logic [DATA_W-1:0] Result,
    output logic [15:0]       OpCount
);

    localparam logic [3:0] OP_LI = 4'b1011;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        WRITE,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [ADDR_W-1:0]  rs_q, rs_d;
    logic [ADDR_W-1:0]  rt_q, rt_d;
    logic [ADDR_W-1:0]  rd_q, rd_d;
    logic [4:0]         shamt_q, shamt_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic [15:0]        op_count_q, op_count_d;

    logic is_li;
    logic is_legal_alu;
    logic is_illegal;

    // Decode the latched op code: load-immediate, legal ALU op, or illegal.
    always_comb begin
        is_li        = (op_q == OP_LI);
        is_legal_alu = 1'b0;
        case (op_q)
            4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8,
            4'd12, 4'd13, 4'd14, 4'd15: is_legal_alu = 1'b1;
            default:                    is_legal_alu = 1'b0;
        endcase
        is_illegal = !is_li && !is_legal_alu;
    end

    // State, latched command, result and completion counter registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            shamt_q    <= '0;
            imm_q      <= '0;
            result_q   <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            shamt_q    <= shamt_d;
            imm_q      <= imm_d;
            result_q   <= result_d;
            op_count_q <= op_count_d;
        end
    end

    // Next-state logic: accept in IDLE, illegal ops skip EXEC/WRITE, result captured in EXEC.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        shamt_d    = shamt_q;
        imm_d      = imm_q;
        result_d   = result_q;
        op_count_d = op_count_q;
        case (state_q)
            IDLE: begin
                if (CmdValid) begin
                    op_d    = CmdOp;
                    rs_d    = CmdRs;
                    rt_d    = CmdRt;
                    rd_d    = CmdRd;
                    shamt_d = CmdShamt;
                    imm_d   = CmdImm;
                    state_d = READ;
                end
            end
            READ: begin
                state_d = is_illegal ? DONE : EXEC;
            end
            EXEC: begin
                result_d = is_li ? imm_q : AluResult;
                state_d  = WRITE;
            end
            WRITE: begin
                // Counted here so OpCount already reflects this command while Done is high.
                op_count_d = op_count_q + 16'd1;
                state_d    = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register-file, ALU and handshake outputs decoded from the current state.
    always_comb begin
        CmdReady   = (state_q == IDLE);
        RR1        = '0;
        RR2        = '0;
        Op         = '0;
        ShiftCount = '0;
        WR         = '0;
        WE         = 1'b0;
        WD         = '0;
        Mux_Ctrl   = 1'b1;
        Done       = 1'b0;
        Err        = 1'b0;
        // ALU operands stay on the read ports through WRITE so AluResult is
        // still valid while the write-data mux selects it.
        if (state_q == READ || state_q == EXEC || state_q == WRITE) begin
            RR1        = rs_q;
            RR2        = rt_q;
            Op         = is_li ? 4'b0000 : op_q;
            ShiftCount = shamt_q;
        end
        if (state_q == WRITE) begin
            WE = 1'b1;
            WR = rd_q;
            if (is_li) begin
                WD       = imm_q;
                Mux_Ctrl = 1'b0;
            end
        end
        if (state_q == DONE) begin
            Done = 1'b1;
            Err  = is_illegal;
        end
    end

    assign Result  = result_q;
    assign OpCount = op_count_q;

endmodule
